// File: rtl/asd_bram.sv
// Simple dual-port block RAM: one write port with byte-lane enables, one read port,
// optional output register stage and a read-data-valid pulse on `a`.
module asd_bram #(
   parameter int          DATA_W = 8,
   parameter int          ADDR_W = 6,
   parameter int          WE_W   = (DATA_W / 8 < 1) ? 1 : DATA_W / 8,
   parameter bit          DO_REG = 1'b1,
   parameter [DATA_W-1:0] SRVAL  = '0
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [DATA_W-1:0] DI,
   input  logic [ADDR_W-1:0] WRADDR,
   input  logic              WREN,
   input  logic [WE_W-1:0]   WE,
   input  logic [ADDR_W-1:0] RDADDR,
   input  logic              RDEN,
   input  logic              REGCE,
   output logic [DATA_W-1:0] DO,
   output logic              a
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int LANE_W = DATA_W / WE_W;

   // NOTE: the array is initialised once and never reset; adding a reset to it
   // would prevent block-RAM inference and RST must leave stored data intact.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic [DATA_W-1:0] latch;
   logic              v1;

   always_ff @(posedge clk) begin
      if (WREN && !RST) begin
         for (int i = 0; i < WE_W; i++) begin
            if (WE[i]) mem[WRADDR][LANE_W*i +: LANE_W] <= DI[LANE_W*i +: LANE_W];
         end
      end
   end

   // Read-first: the latch samples the array value from before this edge's write.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         latch <= SRVAL;
         v1    <= 1'b0;
      end else begin
         v1 <= RDEN;
         if (RDEN) latch <= mem[RDADDR];
      end
   end

   generate
      if (DO_REG) begin : g_do_reg
         logic [DATA_W-1:0] do_q;
         logic              a_q;

         always_ff @(posedge clk or posedge RST) begin
            if (RST) begin
               do_q <= SRVAL;
               a_q  <= 1'b0;
            end else if (REGCE) begin
               do_q <= latch;
               a_q  <= v1;
            end else begin
               a_q  <= 1'b0;
            end
         end

         assign DO = do_q;
         assign a  = a_q;
      end else begin : g_do_latch
         logic unused_regce;
         assign unused_regce = REGCE;
         assign DO = latch;
         assign a  = v1;
      end
   endgenerate

endmodule

// File: tb/tb_asd_bram.sv
// Scoreboard bench for asd_bram: two 16-bit instances (registered and unregistered
// output) share stimulus; monitors pop expected read data whenever `a` pulses.
module tb_asd_bram;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] di;
   logic [5:0]  wraddr;
   logic        wren;
   logic [1:0]  we;
   logic [5:0]  rdaddr;
   logic        rden;
   logic        regce;
   logic [15:0] do_r, do_n;
   logic        a_r, a_n;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q_r [$];
   logic [15:0] q_n [$];

   always #5 clk = ~clk;

   asd_bram #(.DATA_W(16), .ADDR_W(6), .DO_REG(1'b1)) u_dut_r (
      .clk(clk), .RST(rst), .DI(di), .WRADDR(wraddr), .WREN(wren), .WE(we),
      .RDADDR(rdaddr), .RDEN(rden), .REGCE(regce), .DO(do_r), .a(a_r)
   );

   asd_bram #(.DATA_W(16), .ADDR_W(6), .DO_REG(1'b0)) u_dut_n (
      .clk(clk), .RST(rst), .DI(di), .WRADDR(wraddr), .WREN(wren), .WE(we),
      .RDADDR(rdaddr), .RDEN(rden), .REGCE(regce), .DO(do_n), .a(a_n)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] addr, input logic [15:0] data, input logic [1:0] mask);
      wren   = 1'b1;
      wraddr = addr;
      di     = data;
      we     = mask;
      tick();
      wren   = 1'b0;
   endtask

   task automatic rd(input logic [5:0] addr, input logic [15:0] exp, input bit push_r);
      rden   = 1'b1;
      rdaddr = addr;
      q_n.push_back(exp);
      if (push_r) q_r.push_back(exp);
      tick();
      rden   = 1'b0;
   endtask

   // Monitors: sample away from the rising edge, pop on every valid pulse.
   always @(negedge clk) begin : mon_r
      logic [15:0] e;
      if (!rst && a_r) begin
         if (q_r.size() == 0) check("r_spurious_a", {15'd0, a_r}, 16'h0000);
         else begin
            e = q_r.pop_front();
            check("r_do", do_r, e);
         end
      end
   end

   always @(negedge clk) begin : mon_n
      logic [15:0] e;
      if (!rst && a_n) begin
         if (q_n.size() == 0) check("n_spurious_a", {15'd0, a_n}, 16'h0000);
         else begin
            e = q_n.pop_front();
            check("n_do", do_n, e);
         end
      end
   end

   initial begin
      rst = 1'b1; di = '0; wraddr = '0; wren = 1'b0; we = '0;
      rdaddr = '0; rden = 1'b0; regce = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state and idle
      check("rst_do_r", do_r, 16'h0000);
      check("rst_a_r", {15'd0, a_r}, 16'h0000);
      check("rst_do_n", do_n, 16'h0000);
      check("rst_a_n", {15'd0, a_n}, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_do_r", do_r, 16'h0000);
         check("idle_a_r", {15'd0, a_r}, 16'h0000);
         check("idle_a_n", {15'd0, a_n}, 16'h0000);
      end

      // Write then read, two-cycle latency on the registered instance
      wr(6'd3, 16'h00A5, 2'b11);
      rd(6'd3, 16'h00A5, 1'b1);
      check("lat1_a_n", {15'd0, a_n}, 16'h0001);
      check("lat1_a_r", {15'd0, a_r}, 16'h0000);
      tick();
      check("lat2_a_r", {15'd0, a_r}, 16'h0001);
      check("lat2_do_r", do_r, 16'h00A5);
      check("lat2_a_n", {15'd0, a_n}, 16'h0000);
      tick();
      check("lat3_a_r", {15'd0, a_r}, 16'h0000);

      // Read-first collision
      wr(6'd10, 16'h0011, 2'b11);
      wren = 1'b1; wraddr = 6'd10; di = 16'h0022; we = 2'b11;
      rden = 1'b1; rdaddr = 6'd10;
      q_n.push_back(16'h0011);
      q_r.push_back(16'h0011);
      tick();
      wren = 1'b0; rden = 1'b0;
      rd(6'd10, 16'h0022, 1'b1);
      repeat (3) tick();

      // Byte-lane mask and WREN gating
      wr(6'd5, 16'hFFFF, 2'b11);
      wr(6'd5, 16'h1234, 2'b01);
      rd(6'd5, 16'hFF34, 1'b1);
      wren = 1'b0; wraddr = 6'd5; di = 16'h0000; we = 2'b11;
      tick();
      rd(6'd5, 16'hFF34, 1'b1);
      repeat (3) tick();

      // REGCE low: registered output holds, no pulse
      regce = 1'b0;
      rd(6'd10, 16'h0022, 1'b0);
      repeat (3) tick();
      check("regce0_do_r", do_r, 16'hFF34);
      check("regce0_a_r", {15'd0, a_r}, 16'h0000);
      regce = 1'b1;
      tick();
      check("regce1_do_r", do_r, 16'h0022);
      check("regce1_a_r", {15'd0, a_r}, 16'h0000);

      // Boundary sweep: every address holds its own index, read back-to-back
      for (int i = 0; i < 64; i++) wr(6'(i), 16'(i), 2'b11);
      rden = 1'b1;
      for (int i = 0; i < 64; i++) begin
         rdaddr = 6'(i);
         q_n.push_back(16'(i));
         q_r.push_back(16'(i));
         tick();
      end
      rden = 1'b0;
      repeat (4) tick();

      // Reset mid-read discards in-flight data and blocks writes
      wr(6'd3, 16'h00A5, 2'b11);
      rden = 1'b1; rdaddr = 6'd3;
      tick();
      rden = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_do_r", do_r, 16'h0000);
      check("midrst_a_r", {15'd0, a_r}, 16'h0000);
      check("midrst_do_n", do_n, 16'h0000);
      check("midrst_a_n", {15'd0, a_n}, 16'h0000);
      wren = 1'b1; wraddr = 6'd3; di = 16'hBEEF; we = 2'b11;
      repeat (2) tick();
      wren = 1'b0;
      rst  = 1'b0;
      rd(6'd3, 16'h00A5, 1'b1);

      // Bounded drain, then every expected response must have been seen
      for (int i = 0; i < 20 && (q_r.size() != 0 || q_n.size() != 0); i++) tick();
      check("r_queue_left", 16'(q_r.size()), 16'h0000);
      check("n_queue_left", 16'(q_n.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/asd_bram.md
Name: asd_bram

Overview:
- Single-clock, 64-entry simple dual-port block RAM (one write port, one read port) with byte-lane write enables.
- Has an optional pipelined output register and a read-data-valid flag `a`.
- Used as the storage primitive under the FIFO experiments; the FIFO control logic sits outside this block.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8 when wider than 8.
- ADDR_W, 6, address width; depth = 2**ADDR_W = 64.
- WE_W, DATA_W/8 (minimum 1), number of byte-lane write enables.
- DO_REG, 1, 1 = output register stage enabled via REGCE; 0 = latch output drives DO directly.
- SRVAL, 0, value loaded into the read latch and DO on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- DI  in  DATA_W  write data.
- WRADDR  in  ADDR_W  write address.
- WREN  in  1  write port enable.
- WE  in  WE_W  byte-lane write mask; lane i covers DI[8i+7:8i].
- RDADDR  in  ADDR_W  read address.
- RDEN  in  1  read port enable.
- REGCE  in  1  output register clock enable; ignored when DO_REG=0.
- DO  out  DATA_W  read data.
- a  out  1  read-data-valid pulse.

Behaviour:
- Memory array is 2**ADDR_W x DATA_W and initialises to all zeros at time 0. RST does NOT clear the array.
- Write: on a clk edge with WREN=1, every lane i with WE[i]=1 stores DI lane i at mem[WRADDR]. Lanes with WE[i]=0 are unchanged. WREN=0 means no write regardless of WE.
- Read stage 1: on a clk edge with RDEN=1, latch <= mem[RDADDR]. With RDEN=0, latch holds. An internal flag v1 <= RDEN.
- Read-during-write to the same address on the same edge is read-first: latch gets the old contents. Write and read to different addresses are independent.
- DO_REG=0:
  - DO = latch.
  - a = v1, so `a` is high in the cycle after any edge where RDEN=1.
  - Latency is 1 cycle: RDEN at edge k gives data on DO after edge k.
- DO_REG=1:
  - On an edge with REGCE=1: DO <= latch and a <= v1. With REGCE=0, DO holds and a <= 0.
  - Latency is 2 cycles: RDEN at edge k, then REGCE at edge k+1, gives data on DO after edge k+1.
- Reset (asynchronous, active-high): latch, DO <= SRVAL; v1, a <= 0, all taking effect immediately.
  - Reset mid-read discards the in-flight data; no `a` pulse appears for it.
  - Writes are blocked while RST=1.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range condition exists. Address 63 followed by 0 needs no special handling.
- No X on DO after the first reset. All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: assert RST for 2 cycles, release -> DO=0x00, a=0. Idle 5 cycles with RDEN=0 -> DO stays 0x00, a stays 0.
- Write then read (DO_REG=1):
  - Write 0xA5 to address 3 (WREN=1, WE=1).
  - RDEN=1, RDADDR=3 at edge k; REGCE=1 at edge k+1.
  - Required: DO=0xA5 and a=1 after edge k+1; a=0 on the following cycle when RDEN=0.
- Read-first collision: mem[10]=0x11, then on the same edge write 0x22 to address 10 with RDEN=1, RDADDR=10.
  - Required: data read out is 0x11; a subsequent read of address 10 returns 0x22.
- Byte mask (DATA_W=16, WE_W=2):
  - Write 0xFFFF to address 5, then write 0x1234 to address 5 with WE=2'b01.
  - Required: reading address 5 returns 0xFF34. A write with WREN=0 and WE=2'b11 leaves it at 0xFF34.
- Boundary addresses: write address i with value i for i=0..63, then read all 64.
  - Required: each DO equals its address, including 0 and 63.
  - With DO_REG=0: DO is valid 1 cycle after RDEN, and a is high for every read.
- Reset mid-operation:
  - Issue RDEN on address 3 (0xA5 stored), then assert RST asynchronously before the REGCE edge.
  - Required: DO=0x00 and a=0 immediately; after release, mem[3] still reads 0xA5.
